if_prefetch_buffer: RTL and testbench

//  Parametrised instruction-fetch front end for the 5-stage core. It replaces the single-register fetch path.
//  It issues pipelined req/gnt/rvalid fetches to instruction memory, with up to MAX_OUTSTANDING requests in flight.

---
 rtl/if_prefetch_buffer.sv | 195 +++++++++++++++++++
 tb/tb_if_prefetch_buffer.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/if_prefetch_buffer.sv
// Instruction-fetch front end: pipelined req/gnt/rvalid fetch engine feeding a
// DEPTH-entry instruction/PC FIFO, with redirect flush and stale-response discard.
module if_prefetch_buffer #(
    parameter int unsigned           DATA_WIDTH      = 32,
    parameter int unsigned           ADDR_WIDTH      = 32,
    parameter int unsigned           DEPTH           = 4,
    parameter int unsigned           MAX_OUTSTANDING = 2,
    parameter logic [ADDR_WIDTH-1:0] BOOT_ADDR       = {ADDR_WIDTH{1'b0}}
) (
    input  logic                     clk,
    input  logic                     rst_n,
    output logic                     instr_req_o,
    output logic [ADDR_WIDTH-1:0]    instr_addr_o,
    input  logic                     instr_gnt_i,
    input  logic                     instr_rvalid_i,
    input  logic [DATA_WIDTH-1:0]    instr_rdata_i,
    input  logic                     brj_i,
    input  logic [ADDR_WIDTH-1:0]    brj_pc_i,
    input  logic                     stall_i,
    output logic                     d_valid_o,
    output logic [DATA_WIDTH-1:0]    d_instruction_o,
    output logic [ADDR_WIDTH-1:0]    d_pc_o,
    output logic [ADDR_WIDTH-1:0]    d_pc4_o,
    output logic                     flush_inst_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
    localparam int unsigned SUM_W = CNT_W + 1;

    localparam logic [CNT_W-1:0]      CNT_ONE   = CNT_W'(1'b1);
    localparam logic [CNT_W-1:0]      CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]      MAX_CNT   = CNT_W'(MAX_OUTSTANDING);
    localparam logic [SUM_W-1:0]      DEPTH_SUM = SUM_W'(DEPTH);
    localparam logic [PTR_W-1:0]      PTR_ONE   = PTR_W'(1'b1);
    localparam logic [PTR_W-1:0]      PTR_ZERO  = {PTR_W{1'b0}};
    localparam logic [ADDR_WIDTH-1:0] ADDR_STEP = ADDR_WIDTH'(3'b100);

    logic                  req_r;
    logic [ADDR_WIDTH-1:0] fetch_addr_r;
    logic [ADDR_WIDTH-1:0] ret_pc_r;
    logic [CNT_W-1:0]      outstanding_r;
    logic [CNT_W-1:0]      discard_r;
    logic [CNT_W-1:0]      level_r;
    logic [PTR_W-1:0]      wptr_r;
    logic [PTR_W-1:0]      rptr_r;
    logic [DATA_WIDTH-1:0] mem_data_r [DEPTH];
    logic [ADDR_WIDTH-1:0] mem_pc_r   [DEPTH];
    logic                  head_valid_r;
    logic [DATA_WIDTH-1:0] head_data_r;
    logic [ADDR_WIDTH-1:0] head_pc_r;
    logic [ADDR_WIDTH-1:0] head_pc4_r;
    logic                  flush_r;

    logic                  granted_s;
    logic                  drop_s;
    logic                  push_s;
    logic                  pop_s;
    logic                  req_nxt_s;
    logic [ADDR_WIDTH-1:0] fetch_addr_nxt_s;
    logic [ADDR_WIDTH-1:0] ret_pc_nxt_s;
    logic [CNT_W-1:0]      outstanding_nxt_s;
    logic [CNT_W-1:0]      discard_nxt_s;
    logic [CNT_W-1:0]      level_nxt_s;
    logic [PTR_W-1:0]      wptr_nxt_s;
    logic [PTR_W-1:0]      rptr_nxt_s;
    logic [DATA_WIDTH-1:0] head_data_nxt_s;
    logic [ADDR_WIDTH-1:0] head_pc_nxt_s;

    // Next-state computation for fetch engine, discard bookkeeping and FIFO.
    always_comb begin
        granted_s         = req_r & instr_gnt_i;
        drop_s            = instr_rvalid_i & (discard_r != CNT_ZERO);
        push_s            = instr_rvalid_i & ~drop_s & ~brj_i;
        pop_s             = (level_r != CNT_ZERO) & ~stall_i & ~brj_i;
        outstanding_nxt_s = outstanding_r;
        fetch_addr_nxt_s  = fetch_addr_r;
        ret_pc_nxt_s      = ret_pc_r;
        discard_nxt_s     = discard_r;
        level_nxt_s       = level_r;
        wptr_nxt_s        = wptr_r;
        rptr_nxt_s        = rptr_r;
        req_nxt_s         = 1'b0;
        head_data_nxt_s   = head_data_r;
        head_pc_nxt_s     = head_pc_r;

        case ({granted_s, instr_rvalid_i})
            2'b10:   outstanding_nxt_s = outstanding_r + CNT_ONE;
            2'b01:   outstanding_nxt_s = outstanding_r - CNT_ONE;
            default: outstanding_nxt_s = outstanding_r;
        endcase

        // Every response still in flight after a redirect belongs to the old path.
        if (brj_i) begin
            fetch_addr_nxt_s = brj_pc_i;
            ret_pc_nxt_s     = brj_pc_i;
            discard_nxt_s    = outstanding_nxt_s;
            level_nxt_s      = CNT_ZERO;
            wptr_nxt_s       = PTR_ZERO;
            rptr_nxt_s       = PTR_ZERO;
        end else begin
            if (granted_s) begin
                fetch_addr_nxt_s = fetch_addr_r + ADDR_STEP;
            end else begin
                fetch_addr_nxt_s = fetch_addr_r;
            end
            if (push_s) begin
                ret_pc_nxt_s = ret_pc_r + ADDR_STEP;
                wptr_nxt_s   = wptr_r + PTR_ONE;
            end else begin
                ret_pc_nxt_s = ret_pc_r;
                wptr_nxt_s   = wptr_r;
            end
            if (pop_s) begin
                rptr_nxt_s = rptr_r + PTR_ONE;
            end else begin
                rptr_nxt_s = rptr_r;
            end
            if (drop_s) begin
                discard_nxt_s = discard_r - CNT_ONE;
            end else begin
                discard_nxt_s = discard_r;
            end
            case ({push_s, pop_s})
                2'b10:   level_nxt_s = level_r + CNT_ONE;
                2'b01:   level_nxt_s = level_r - CNT_ONE;
                default: level_nxt_s = level_r;
            endcase
        end

        req_nxt_s = (outstanding_nxt_s < MAX_CNT) &&
                    (({1'b0, outstanding_nxt_s} + {1'b0, level_nxt_s}) < DEPTH_SUM);

        // A word pushed into a FIFO that empties this cycle becomes the head directly.
        if (push_s && (wptr_r == rptr_nxt_s)) begin
            head_data_nxt_s = instr_rdata_i;
            head_pc_nxt_s   = ret_pc_r;
        end else begin
            head_data_nxt_s = mem_data_r[rptr_nxt_s];
            head_pc_nxt_s   = mem_pc_r[rptr_nxt_s];
        end
    end

    // State and registered outputs, with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            req_r         <= 1'b0;
            fetch_addr_r  <= BOOT_ADDR;
            ret_pc_r      <= BOOT_ADDR;
            outstanding_r <= CNT_ZERO;
            discard_r     <= CNT_ZERO;
            level_r       <= CNT_ZERO;
            wptr_r        <= PTR_ZERO;
            rptr_r        <= PTR_ZERO;
            head_valid_r  <= 1'b0;
            head_data_r   <= {DATA_WIDTH{1'b0}};
            head_pc_r     <= {ADDR_WIDTH{1'b0}};
            head_pc4_r    <= ADDR_STEP;
            flush_r       <= 1'b0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_data_r[i] <= {DATA_WIDTH{1'b0}};
                mem_pc_r[i]   <= {ADDR_WIDTH{1'b0}};
            end
        end else begin
            req_r         <= req_nxt_s;
            fetch_addr_r  <= fetch_addr_nxt_s;
            ret_pc_r      <= ret_pc_nxt_s;
            outstanding_r <= outstanding_nxt_s;
            discard_r     <= discard_nxt_s;
            level_r       <= level_nxt_s;
            wptr_r        <= wptr_nxt_s;
            rptr_r        <= rptr_nxt_s;
            head_valid_r  <= (level_nxt_s != CNT_ZERO);
            head_data_r   <= head_data_nxt_s;
            head_pc_r     <= head_pc_nxt_s;
            head_pc4_r    <= head_pc_nxt_s + ADDR_STEP;
            flush_r       <= brj_i;
            if (push_s) begin
                mem_data_r[wptr_r] <= instr_rdata_i;
                mem_pc_r[wptr_r]   <= ret_pc_r;
            end
        end
    end

    assign instr_req_o     = req_r;
    assign instr_addr_o    = fetch_addr_r;
    assign d_valid_o       = head_valid_r;
    assign d_instruction_o = head_data_r;
    assign d_pc_o          = head_pc_r;
    assign d_pc4_o         = head_pc4_r;
    assign flush_inst_o    = flush_r;
    assign level_o         = level_r;

endmodule

// File: tb/tb_if_prefetch_buffer.sv
// Directed bench for if_prefetch_buffer: in-order memory model with optional
// response hold, hand-computed expectations checked with immediate assertions.
module tb_if_prefetch_buffer;

    logic        clk;
    logic        rst_n;
    logic        instr_req_o;
    logic [31:0] instr_addr_o;
    logic        instr_gnt_i;
    logic        instr_rvalid_i;
    logic [31:0] instr_rdata_i;
    logic        brj_i;
    logic [31:0] brj_pc_i;
    logic        stall_i;
    logic        d_valid_o;
    logic [31:0] d_instruction_o;
    logic [31:0] d_pc_o;
    logic [31:0] d_pc4_o;
    logic        flush_inst_o;
    logic [2:0]  level_o;

    int          checks;
    int          failures;
    logic        resp_en;
    logic [31:0] mem_q [$];

    if_prefetch_buffer dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .instr_req_o     (instr_req_o),
        .instr_addr_o    (instr_addr_o),
        .instr_gnt_i     (instr_gnt_i),
        .instr_rvalid_i  (instr_rvalid_i),
        .instr_rdata_i   (instr_rdata_i),
        .brj_i           (brj_i),
        .brj_pc_i        (brj_pc_i),
        .stall_i         (stall_i),
        .d_valid_o       (d_valid_o),
        .d_instruction_o (d_instruction_o),
        .d_pc_o          (d_pc_o),
        .d_pc4_o         (d_pc4_o),
        .flush_inst_o    (flush_inst_o),
        .level_o         (level_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] data_of(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // One clock: memory sees the grant before the edge, answers in the next cycle.
    task automatic tick();
        logic        granted;
        logic [31:0] gaddr;
        granted = instr_req_o & instr_gnt_i;
        gaddr   = instr_addr_o;
        @(posedge clk);
        #1;
        if (granted === 1'b1) mem_q.push_back(gaddr);
        if (rst_n) mem_q.delete();
        if (resp_en && !rst_n && mem_q.size() > 0) begin
            instr_rvalid_i = 1'b1;
            instr_rdata_i  = data_of(mem_q.pop_front());
        end else begin
            instr_rvalid_i = 1'b0;
            instr_rdata_i  = 32'h0;
        end
    endtask

    initial begin
        checks = 0; failures = 0;
        rst_n = 1'b1; instr_gnt_i = 1'b0; instr_rvalid_i = 1'b0; instr_rdata_i = 32'h0;
        brj_i = 1'b0; brj_pc_i = 32'h0; stall_i = 1'b0; resp_en = 1'b1;
        #1;
        repeat (3) tick();
        chk("rst_req",   32'(instr_req_o),  32'h0);
        chk("rst_addr",  instr_addr_o,      32'h0);
        chk("rst_valid", 32'(d_valid_o),    32'h0);
        chk("rst_instr", d_instruction_o,   32'h0);
        chk("rst_pc",    d_pc_o,            32'h0);
        chk("rst_pc4",   d_pc4_o,           32'h4);
        chk("rst_flush", 32'(flush_inst_o), 32'h0);
        chk("rst_level", 32'(level_o),      32'h0);

        // Streaming fetch, gnt always, 1-cycle response latency
        instr_gnt_i = 1'b1; rst_n = 1'b0;
        tick();
        chk("t1_req_first", 32'(instr_req_o), 32'h1);
        chk("t1_addr0",     instr_addr_o,     32'h0);
        tick();
        chk("t1_addr4",     instr_addr_o,     32'h4);
        chk("t1_nvalid",    32'(d_valid_o),   32'h0);
        tick();
        chk("t1_valid",     32'(d_valid_o),   32'h1);
        chk("t1_pc0",       d_pc_o,           32'h0);
        chk("t1_instr0",    d_instruction_o,  data_of(32'h0));
        chk("t1_pc4_0",     d_pc4_o,          32'h4);
        chk("t1_level",     32'(level_o),     32'h1);
        tick();
        chk("t1_pc4",       d_pc_o,           32'h4);
        chk("t1_instr4",    d_instruction_o,  data_of(32'h4));
        tick();
        chk("t1_pc8",       d_pc_o,           32'h8);
        chk("t1_addr16",    instr_addr_o,     32'h10);

        // Stall until the FIFO fills, then drain in order
        stall_i = 1'b1;
        repeat (4) tick();
        chk("t2_level_full", 32'(level_o),     32'h4);
        chk("t2_req_off",    32'(instr_req_o), 32'h0);
        chk("t2_head_held",  d_pc_o,           32'h8);
        chk("t2_addr_held",  instr_addr_o,     32'h18);
        stall_i = 1'b0;
        tick();
        chk("t2_pc12",       d_pc_o,           32'hC);
        chk("t2_level3",     32'(level_o),     32'h3);
        chk("t2_req_on",     32'(instr_req_o), 32'h1);
        tick();
        chk("t2_pc16",       d_pc_o,           32'h10);
        tick();
        chk("t2_pc20",       d_pc_o,           32'h14);
        tick();
        chk("t2_pc24",       d_pc_o,           32'h18);
        chk("t2_instr24",    d_instruction_o,  data_of(32'h18));

        // Reset in the middle of traffic
        rst_n = 1'b1;
        repeat (2) tick();
        chk("mrst_level", 32'(level_o),     32'h0);
        chk("mrst_req",   32'(instr_req_o), 32'h0);
        chk("mrst_valid", 32'(d_valid_o),   32'h0);
        chk("mrst_addr",  instr_addr_o,     32'h0);

        // Two outstanding, then redirect to 0x100
        rst_n = 1'b0; resp_en = 1'b0;
        repeat (3) tick();
        chk("t3_req_capped", 32'(instr_req_o), 32'h0);
        chk("t3_addr8",      instr_addr_o,     32'h8);
        brj_i = 1'b1; brj_pc_i = 32'h100; resp_en = 1'b1;
        tick();
        brj_i = 1'b0;
        chk("t3_flush",      32'(flush_inst_o), 32'h1);
        chk("t3_addr100",    instr_addr_o,      32'h100);
        chk("t3_nvalid",     32'(d_valid_o),    32'h0);
        tick();
        chk("t3_flush_end",  32'(flush_inst_o), 32'h0);
        chk("t3_drop0",      32'(d_valid_o),    32'h0);
        chk("t3_req_back",   32'(instr_req_o),  32'h1);
        tick();
        chk("t3_drop4",      32'(level_o),      32'h0);
        tick();
        chk("t3_valid",      32'(d_valid_o),    32'h1);
        chk("t3_pc100",      d_pc_o,            32'h100);
        chk("t3_instr100",   d_instruction_o,   data_of(32'h100));
        chk("t3_pc4_104",    d_pc4_o,           32'h104);

        // Redirect coinciding with rvalid and gnt
        brj_i = 1'b1; brj_pc_i = 32'h200;
        tick();
        brj_i = 1'b0;
        chk("t4_level0",     32'(level_o),      32'h0);
        chk("t4_nvalid",     32'(d_valid_o),    32'h0);
        chk("t4_flush",      32'(flush_inst_o), 32'h1);
        chk("t4_addr200",    instr_addr_o,      32'h200);
        tick();
        chk("t4_drop_gnt",   32'(d_valid_o),    32'h0);
        tick();
        chk("t4_pc200",      d_pc_o,            32'h200);
        chk("t4_instr200",   d_instruction_o,   data_of(32'h200));
        chk("t4_level1",     32'(level_o),      32'h1);

        // Grant withheld for three cycles
        instr_gnt_i = 1'b0;
        tick();
        chk("t5_addr_hold1", instr_addr_o,     32'h208);
        chk("t5_req_hold",   32'(instr_req_o), 32'h1);
        tick();
        chk("t5_addr_hold2", instr_addr_o,     32'h208);
        tick();
        chk("t5_addr_hold3", instr_addr_o,     32'h208);
        chk("t5_empty",      32'(level_o),     32'h0);
        instr_gnt_i = 1'b1;
        tick();
        instr_gnt_i = 1'b0;
        chk("t5_addr_adv",   instr_addr_o,     32'h20C);
        tick();
        chk("t5_pc208",      d_pc_o,           32'h208);
        chk("t5_one_entry",  32'(level_o),     32'h1);
        tick();
        chk("t5_drained",    32'(level_o),     32'h0);
        chk("t5_nvalid",     32'(d_valid_o),   32'h0);

        // Address wrap at the top of the address space
        brj_i = 1'b1; brj_pc_i = 32'hFFFF_FFF8; instr_gnt_i = 1'b1; stall_i = 1'b1;
        tick();
        brj_i = 1'b0;
        chk("t6_addr_fff8",  instr_addr_o,     32'hFFFF_FFF8);
        tick();
        chk("t6_drop_stale", 32'(d_valid_o),   32'h0);
        tick();
        chk("t6_addr_wrap",  instr_addr_o,     32'h0);
        chk("t6_pc_fff8",    d_pc_o,           32'hFFFF_FFF8);
        chk("t6_pc4_fffc",   d_pc4_o,          32'hFFFF_FFFC);
        tick();
        chk("t6_level2",     32'(level_o),     32'h2);
        stall_i = 1'b0;
        tick();
        chk("t6_pc_fffc",    d_pc_o,           32'hFFFF_FFFC);
        chk("t6_pc4_wrap",   d_pc4_o,          32'h0);
        chk("t6_instr_fffc", d_instruction_o,  data_of(32'hFFFF_FFFC));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
